// File: rtl/cpu_pkg.sv
// Shared widths and the writeback queue entry type for the register-file write side.
package cpu_pkg;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 2;
  localparam int NUM_REGS = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Ordered writeback queue: two write ports per cycle (port 0 lands first), one read port.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr0_en_i,
  input  wb_entry_t     wr0_data_i,
  input  logic          wr1_en_i,
  input  wb_entry_t     wr1_data_i,
  input  logic          rd_en_i,
  output wb_entry_t     rd_data_o,
  output logic [CW-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);

  wb_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d, wr1Ptr;
  logic [CW-1:0]     count_q, count_d;

  function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Port 1 lands just behind port 0 when both write in the same cycle.
  always_comb begin
    wr1Ptr  = wr0_en_i ? ptrInc(wrPtr_q) : wrPtr_q;
    wrPtr_d = wrPtr_q;
    if (wr0_en_i) wrPtr_d = ptrInc(wrPtr_d);
    if (wr1_en_i) wrPtr_d = ptrInc(wrPtr_d);
    rdPtr_d = rd_en_i ? ptrInc(rdPtr_q) : rdPtr_q;
    count_d = count_q + CW'(wr0_en_i) + CW'(wr1_en_i) - CW'(rd_en_i);
  end

  always_ff @(posedge clk) begin
    if (wr0_en_i) mem_q[wrPtr_q] <= wr0_data_i;
    if (wr1_en_i) mem_q[wr1Ptr]  <= wr1_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  assign rd_data_o = mem_q[rdPtr_q];
  assign count_o   = count_q;
endmodule

// File: rtl/regfile_writeback_ctrl.sv
// Write-side controller for the register file: queues ALU/load results, issues one write
// per cycle, and tracks per-register pending writes until they become readable.
module regfile_writeback_ctrl
  import cpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RF_LAT     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alu_valid,
  input  logic [ADDR_W-1:0]   alu_addr,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_ready,
  input  logic                mem_valid,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                mem_ready,
  input  logic                claim_valid,
  input  logic [ADDR_W-1:0]   claim_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic                rf_wr_en,
  output logic [ADDR_W-1:0]   rf_wr_addr,
  output logic [DATA_W-1:0]   rf_wr_data,
  output logic                idle
);
  localparam int CW      = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + RF_LAT + 2) + 1;
  localparam int CNT_MAX = (2 ** CNT_W) - 1;

  logic [CW-1:0]     count, space;
  logic              aluAcc, memAcc, pop, anyPend;
  wb_entry_t         head;
  logic              rfWrEn_q;
  logic [ADDR_W-1:0] rfWrAddr_q;
  logic [DATA_W-1:0] rfWrData_q;
  logic [RF_LAT-1:0] lineVld_q;
  logic [ADDR_W-1:0] lineAddr_q [RF_LAT];
  logic [CNT_W-1:0]  pend_q [NUM_REGS];
  logic [CNT_W-1:0]  pend_d [NUM_REGS];

  // Space comes from the registered count only; a same-cycle pop earns no credit.
  assign space     = CW'(FIFO_DEPTH) - count;
  assign mem_ready = rst_n && (space >= CW'(1));
  assign alu_ready = rst_n && ((space >= CW'(2)) || ((space >= CW'(1)) && !mem_valid));
  assign memAcc    = mem_valid && mem_ready;
  assign aluAcc    = alu_valid && alu_ready;
  assign pop       = (count != '0);

  wb_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr0_en_i   (memAcc),
    .wr0_data_i ('{addr: mem_addr, data: mem_data}),
    .wr1_en_i   (aluAcc),
    .wr1_data_i ('{addr: alu_addr, data: alu_data}),
    .rd_en_i    (pop),
    .rd_data_o  (head),
    .count_o    (count)
  );

  // Claims and ALU accepts add, a write leaving the shift line subtracts; all sum per cycle.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      int nxt;
      nxt = int'(pend_q[i])
          + int'(claim_valid && (claim_addr == ADDR_W'(i)))
          + int'(aluAcc && (alu_addr == ADDR_W'(i)))
          - int'(lineVld_q[RF_LAT-1] && (lineAddr_q[RF_LAT-1] == ADDR_W'(i)));
      if (nxt < 0)            pend_d[i] = '0;
      else if (nxt > CNT_MAX) pend_d[i] = CNT_W'(CNT_MAX);
      else                    pend_d[i] = CNT_W'(nxt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rfWrEn_q   <= 1'b0;
      rfWrAddr_q <= '0;
      rfWrData_q <= '0;
      lineVld_q  <= '0;
      for (int i = 0; i < RF_LAT; i++)   lineAddr_q[i] <= '0;
      for (int i = 0; i < NUM_REGS; i++) pend_q[i] <= '0;
    end else begin
      rfWrEn_q <= pop;
      if (pop) begin
        rfWrAddr_q <= head.addr;
        rfWrData_q <= head.data;
      end
      lineVld_q[0]  <= pop;
      lineAddr_q[0] <= head.addr;
      for (int i = 1; i < RF_LAT; i++) begin
        lineVld_q[i]  <= lineVld_q[i-1];
        lineAddr_q[i] <= lineAddr_q[i-1];
      end
      for (int i = 0; i < NUM_REGS; i++) pend_q[i] <= pend_d[i];
    end
  end

  always_comb begin
    anyPend = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy[i] = (pend_q[i] != '0);
      anyPend = anyPend | busy[i];
    end
  end

  assign rf_wr_en   = rfWrEn_q;
  assign rf_wr_addr = rfWrAddr_q;
  assign rf_wr_data = rfWrData_q;
  assign idle       = (count == '0) && !anyPend && !rfWrEn_q && (lineVld_q == '0);
endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Randomized scoreboard bench for regfile_writeback_ctrl; the model schedules each accepted
// result's issue cycle and visibility cycle directly from the ordering/latency rules.
module tb_regfile_writeback_ctrl;
  import cpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                alu_valid = 1'b0, mem_valid = 1'b0, claim_valid = 1'b0;
  logic [ADDR_W-1:0]   alu_addr = '0, mem_addr = '0, claim_addr = '0;
  logic [DATA_W-1:0]   alu_data = '0, mem_data = '0;
  logic                alu_ready, mem_ready, rf_wr_en, idle;
  logic [NUM_REGS-1:0] busy;
  logic [ADDR_W-1:0]   rf_wr_addr;
  logic [DATA_W-1:0]   rf_wr_data;

  regfile_writeback_ctrl #(.FIFO_DEPTH(DEPTH), .RF_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .claim_valid(claim_valid), .claim_addr(claim_addr),
    .busy(busy), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .idle(idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   issue;
    int   addr;
    int   data;
  } exp_t;

  exp_t expQ[$];
  int   fifoIssue[$];
  int   decAt[$];
  int   decAddr[$];
  int   claimQ[$];
  int   pend[NUM_REGS];
  int   lastIssue = -100;
  int   vectors = 0;
  int   miscompares = 0;
  logic inReset = 1'b1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
    end
  endtask

  task automatic clearModel();
    expQ.delete();
    fifoIssue.delete();
    decAt.delete();
    decAddr.delete();
    claimQ.delete();
    for (int i = 0; i < NUM_REGS; i++) pend[i] = 0;
    lastIssue = -100;
  endtask

  // A result accepted at edge acc leaves the queue one edge later at the earliest, one per edge, in order.
  task automatic pushEntry(input int addr, input int data, input int acc);
    exp_t e;
    e.issue   = (acc + 1 > lastIssue + 1) ? acc + 1 : lastIssue + 1;
    e.addr    = addr;
    e.data    = data;
    lastIssue = e.issue;
    expQ.push_back(e);
    fifoIssue.push_back(e.issue);
    decAt.push_back(e.issue + LAT);
    decAddr.push_back(addr);
  endtask

  // Monitor: every write presented on the register-file port must be the next scheduled one.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && !inReset) begin
        if (rf_wr_en) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_write", 1, 0);
          end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("write_cycle", cyc, e.issue);
            checkOutput("write_addr", int'(rf_wr_addr), e.addr);
            checkOutput("write_data", int'(rf_wr_data), e.data);
          end
        end else if (expQ.size() > 0 && expQ[0].issue <= cyc) begin
          checkOutput("missed_write", 0, 1);
          void'(expQ.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(input int pAlu, input int pMem, input int pClaim);
    int expBusy, space, acc;
    bit expMemRdy, expAluRdy;
    @(negedge clk);
    while (decAt.size() > 0 && decAt[0] <= cyc) begin
      int a;
      a = decAddr.pop_front();
      void'(decAt.pop_front());
      pend[a]--;
      if (pend[a] < 0) begin
        checkOutput("pending_underflow", pend[a], 0);
        pend[a] = 0;
      end
    end
    while (fifoIssue.size() > 0 && fifoIssue[0] <= cyc) void'(fifoIssue.pop_front());

    expBusy = 0;
    for (int i = 0; i < NUM_REGS; i++) if (pend[i] > 0) expBusy |= (1 << i);
    checkOutput("busy", int'(busy), expBusy);
    checkOutput("idle", int'(idle), int'(expBusy == 0 && lastIssue <= cyc - LAT));

    alu_valid   = ($urandom_range(99) < pAlu);
    alu_addr    = ADDR_W'($urandom);
    alu_data    = DATA_W'($urandom);
    mem_valid   = (claimQ.size() > 0) && ($urandom_range(99) < pMem);
    mem_addr    = (claimQ.size() > 0) ? ADDR_W'(claimQ[0]) : '0;
    mem_data    = DATA_W'($urandom);
    claim_valid = (claimQ.size() < 3) && ($urandom_range(99) < pClaim);
    claim_addr  = ADDR_W'($urandom);
    #1;

    space     = DEPTH - fifoIssue.size();
    expMemRdy = (space >= 1);
    expAluRdy = (space >= 2) || (space >= 1 && !mem_valid);
    checkOutput("mem_ready", int'(mem_ready), int'(expMemRdy));
    checkOutput("alu_ready", int'(alu_ready), int'(expAluRdy));

    acc = cyc + 1;
    if (mem_valid && expMemRdy) begin
      pushEntry(int'(mem_addr), int'(mem_data), acc);
      void'(claimQ.pop_front());
    end
    if (alu_valid && expAluRdy) begin
      pushEntry(int'(alu_addr), int'(alu_data), acc);
      pend[alu_addr]++;
    end
    if (claim_valid) begin
      pend[claim_addr]++;
      claimQ.push_back(int'(claim_addr));
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    #2;
    rst_n       = 1'b0;
    inReset     = 1'b1;
    alu_valid   = 1'b0;
    mem_valid   = 1'b0;
    claim_valid = 1'b0;
    clearModel();
    #1;
    checkOutput("reset_rf_wr_en", int'(rf_wr_en), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_alu_ready", int'(alu_ready), 0);
    checkOutput("reset_mem_ready", int'(mem_ready), 0);
    checkOutput("reset_idle", int'(idle), 1);
    checkOutput("reset_rf_wr_addr", int'(rf_wr_addr), 0);
    checkOutput("reset_rf_wr_data", int'(rf_wr_data), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n   = 1'b1;
    inReset = 1'b0;
  endtask

  initial begin
    clearModel();
    $display("[TB] starting regfile_writeback_ctrl bench");
    applyReset();

    repeat (300) applyStimulus(40, 50, 30);
    repeat (200) applyStimulus(100, 100, 80);
    applyReset();
    repeat (10) applyStimulus(0, 0, 0);
    repeat (300) applyStimulus(70, 60, 40);
    repeat (150) applyStimulus(90, 90, 60);
    applyReset();
    repeat (200) applyStimulus(30, 80, 50);
    repeat (40) applyStimulus(0, 100, 0);

    checkOutput("drained_queue", expQ.size(), 0);
    checkOutput("final_idle", int'(idle), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
